// File: rtl/operand_source.sv
`default_nettype none
// ============================================================================
// Module   : operand_source
// Purpose  : Emits a burst of (x, y) operand pairs over a dual dav/rfd
//            four-phase handshake and optionally accumulates returned products.
// Options  : define OPERAND_SOURCE_ACCUM_EN to enable the product accumulator.
// Revision : 1.0
// ============================================================================
module operand_source (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  base_x,
    input  logic [7:0]  base_y,
    input  logic [3:0]  len,
    output logic [7:0]  x,
    output logic [7:0]  y,
    output logic        dav1_,
    output logic        dav2_,
    input  logic        rfd1,
    input  logic        rfd2,
    input  logic [15:0] m,
    input  logic        ok,
    output logic [19:0] acc,
    output logic        busy,
    output logic        done
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_PRESENT = 3'd1;
    localparam logic [2:0] S_HOLD    = 3'd2;
    localparam logic [2:0] S_RELEASE = 3'd3;
    localparam logic [2:0] S_FINISH  = 3'd4;

    logic [2:0] r_state;
    logic [3:0] r_idx;
    logic [3:0] r_last_idx;
    logic [7:0] r_base_x;
    logic [7:0] r_base_y;
    logic       r_dav_n;

    logic w_both_ready;
    logic w_both_low;
    logic w_hold_exit;
    logic w_load;

    assign w_both_ready = rfd1 & rfd2;
    assign w_both_low   = ~rfd1 & ~rfd2;
    assign w_load       = start & ((r_state == S_IDLE) | (r_state == S_FINISH));

`ifdef OPERAND_SOURCE_ACCUM_EN
    assign w_hold_exit = w_both_low & ok;
`else
    assign w_hold_exit = w_both_low;
`endif

    // Both strobes come from one register so they can never disagree.
    assign dav1_ = r_dav_n;
    assign dav2_ = r_dav_n;
    assign busy  = (r_state == S_PRESENT) | (r_state == S_HOLD) | (r_state == S_RELEASE);
    assign done  = (r_state == S_FINISH);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_idx      <= 4'd0;
            r_last_idx <= 4'd0;
            r_base_x   <= 8'd0;
            r_base_y   <= 8'd0;
            x          <= 8'd0;
            y          <= 8'd0;
            r_dav_n    <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE, S_FINISH: begin
                    if (start) begin
                        r_base_x   <= base_x;
                        r_base_y   <= base_y;
                        r_last_idx <= len - 4'd1;   // len = 0 wraps to 15, i.e. 16 pairs
                        r_idx      <= 4'd0;
                        r_state    <= S_PRESENT;
                    end
                end
                S_PRESENT: begin
                    if (w_both_ready) begin
                        x       <= r_base_x + {4'd0, r_idx};
                        y       <= r_base_y;
                        r_dav_n <= 1'b0;
                        r_state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (w_hold_exit) begin
                        r_dav_n <= 1'b1;
                        r_state <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    if (w_both_ready) begin
                        if (r_idx == r_last_idx) begin
                            r_state <= S_FINISH;
                        end else begin
                            r_idx   <= r_idx + 4'd1;
                            r_state <= S_PRESENT;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_dav_n <= 1'b1;
                end
            endcase
        end
    end

`ifdef OPERAND_SOURCE_ACCUM_EN
    logic [19:0] r_acc;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_acc <= 20'd0;
        end else if (w_load) begin
            r_acc <= 20'd0;
        end else if ((r_state == S_HOLD) && w_hold_exit) begin
            r_acc <= r_acc + {4'd0, m};
        end
    end

    assign acc = r_acc;
`else
    logic unused_inputs;

    assign unused_inputs = ^{m, ok, w_load};
    assign acc           = 20'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_operand_source.sv
`default_nettype none
// Directed self-checking bench for operand_source; expectations follow the
// build option (accumulator enabled or constant zero).
module tb_operand_source;

`ifdef OPERAND_SOURCE_ACCUM_EN
    localparam bit ACCUM = 1'b1;
`else
    localparam bit ACCUM = 1'b0;
`endif

    logic        clock;
    logic        reset;
    logic        start;
    logic [7:0]  base_x;
    logic [7:0]  base_y;
    logic [3:0]  len;
    logic [7:0]  x;
    logic [7:0]  y;
    logic        dav1_;
    logic        dav2_;
    logic        rfd1;
    logic        rfd2;
    logic [15:0] m;
    logic        ok;
    logic [19:0] acc;
    logic        busy;
    logic        done;

    int n_pass;
    int n_total;

    operand_source dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .base_x (base_x),
        .base_y (base_y),
        .len    (len),
        .x      (x),
        .y      (y),
        .dav1_  (dav1_),
        .dav2_  (dav2_),
        .rfd1   (rfd1),
        .rfd2   (rfd2),
        .m      (m),
        .ok     (ok),
        .acc    (acc),
        .busy   (busy),
        .done   (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic begin_burst(input logic [7:0] bx, input logic [7:0] by, input logic [3:0] ln);
        base_x = bx;
        base_y = by;
        len    = ln;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        check("start_busy", {31'd0, busy}, 32'd1);
        check("start_done", {31'd0, done}, 32'd0);
        check("start_acc_clr", {12'd0, acc}, 32'd0);
    endtask

    // Ideal multiplying consumer for one pair; stall2 keeps rfd2 high after rfd1 drops.
    task automatic do_pair(input logic [7:0] ex, input logic [7:0] ey, input int stall2,
                           input logic ok_val, input int exp_lat);
        int cyc;
        cyc = 0;
        while (dav1_ !== 1'b0 && cyc < 20) begin
            tick();
            cyc++;
        end
        check("pair_latency", cyc, exp_lat);
        check("pair_dav1", {31'd0, dav1_}, 32'd0);
        check("pair_dav2", {31'd0, dav2_}, 32'd0);
        check("pair_x", {24'd0, x}, {24'd0, ex});
        check("pair_y", {24'd0, y}, {24'd0, ey});
        m    = 16'(ex * ey);
        ok   = ok_val;
        rfd1 = 1'b0;
        rfd2 = (stall2 > 0);
        for (int k = 0; k < stall2; k++) begin
            tick();
            check("stall_dav1", {31'd0, dav1_}, 32'd0);
            check("stall_dav2", {31'd0, dav2_}, 32'd0);
            check("stall_x", {24'd0, x}, {24'd0, ex});
            check("stall_y", {24'd0, y}, {24'd0, ey});
        end
        rfd2 = 1'b0;
        tick();
        check("release_dav", {30'd0, dav1_, dav2_}, 32'd3);
        check("release_busy", {31'd0, busy}, 32'd1);
        ok   = 1'b0;
        m    = 16'd0;
        rfd1 = 1'b1;
        rfd2 = 1'b1;
    endtask

    task automatic finish_check(input logic [19:0] exp_acc, input logic [7:0] last_x);
        tick();
        check("fin_done", {31'd0, done}, 32'd1);
        check("fin_busy", {31'd0, busy}, 32'd0);
        check("fin_dav", {30'd0, dav1_, dav2_}, 32'd3);
        check("fin_acc", {12'd0, acc}, {12'd0, exp_acc});
        check("fin_x_held", {24'd0, x}, {24'd0, last_x});
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        reset   = 1'b1;
        start   = 1'b0;
        base_x  = 8'd0;
        base_y  = 8'd0;
        len     = 4'd0;
        rfd1    = 1'b1;
        rfd2    = 1'b1;
        m       = 16'd0;
        ok      = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        check("rst_dav", {30'd0, dav1_, dav2_}, 32'd3);
        check("rst_xy", {16'd0, x, y}, 32'd0);
        check("rst_acc", {12'd0, acc}, 32'd0);
        check("rst_busy_done", {30'd0, busy, done}, 32'd0);

        // Burst A: (3,5),(4,5); a start pulse between pairs must be ignored.
        begin_burst(8'd3, 8'd5, 4'd2);
        do_pair(8'd3, 8'd5, 0, 1'b1, 1);
        base_x = 8'h80;
        base_y = 8'h80;
        len    = 4'd7;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        check("busy_start_ign", {31'd0, busy}, 32'd1);
        do_pair(8'd4, 8'd5, 0, 1'b1, 1);
        finish_check(ACCUM ? 20'd35 : 20'd0, 8'd4);

        // Burst B from FINISH: 16 pairs, x wraps 0xFF -> 0x0E; sum = 255*360.
        begin_burst(8'hFF, 8'hFF, 4'd0);
        for (int k = 0; k < 16; k++) begin
            do_pair(8'(8'hFF + k), 8'hFF, 0, 1'b1, (k == 0) ? 1 : 2);
        end
        finish_check(ACCUM ? 20'd91800 : 20'd0, 8'h0E);

        // Burst C: rfd2 lags rfd1 by 5 cycles; without the accumulator ok stays low.
        begin_burst(8'h10, 8'h02, 4'd1);
        do_pair(8'h10, 8'h02, 5, ACCUM, 1);
        finish_check(ACCUM ? 20'd32 : 20'd0, 8'h10);

        // Burst D: mismatched rfd blocks PRESENT, then reset lands mid-HOLD.
        rfd2 = 1'b0;
        begin_burst(8'd7, 8'd9, 4'd3);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("mismatch_dav", {30'd0, dav1_, dav2_}, 32'd3);
        end
        rfd2 = 1'b1;
        do_pair(8'd7, 8'd9, 0, 1'b1, 1);
        tick();
        tick();
        check("d_hold_dav", {31'd0, dav1_}, 32'd0);
        check("d_hold_x", {24'd0, x}, 32'd8);
        check("d_acc_pre", {12'd0, acc}, ACCUM ? 32'd63 : 32'd0);
        m     = 16'd72;
        ok    = 1'b1;
        rfd1  = 1'b0;
        rfd2  = 1'b0;
        reset = 1'b1;
        #2;
        check("async_rst_dav", {30'd0, dav1_, dav2_}, 32'd3);
        check("async_rst_acc", {12'd0, acc}, 32'd0);
        check("async_rst_busy", {31'd0, busy}, 32'd0);
        check("async_rst_done", {31'd0, done}, 32'd0);
        check("async_rst_x", {24'd0, x}, 32'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        tick();
        check("post_rst_acc", {12'd0, acc}, 32'd0);
        check("post_rst_idle", {30'd0, busy, done}, 32'd0);
        check("post_rst_dav", {30'd0, dav1_, dav2_}, 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
